// File: rtl/slv_req_arbiter.sv
// rtl/slv_req_arbiter.sv - round-robin arbiter sharing one register-slave port among N_REQ requesters
// One access in flight at a time, with a watchdog that aborts a hung slave access.
module slv_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_vld,
    input  logic [N_REQ-1:0]              req_wr_en,
    input  logic [N_REQ-1:0]              req_rd_en,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wr_data,
    output logic [N_REQ-1:0]              req_ack_vld,
    output logic [N_REQ*DATA_WIDTH-1:0]   req_rd_data,
    output logic [N_REQ-1:0]              req_err,
    output logic                          if_req_vld,
    output logic                          if_wr_en,
    output logic                          if_rd_en,
    output logic [ADDR_WIDTH-1:0]         if_addr,
    output logic [DATA_WIDTH-1:0]         if_wr_data,
    output logic                          if_soft_rst,
    input  logic                          if_ack_vld,
    input  logic [DATA_WIDTH-1:0]         if_rd_data,
    input  logic                          if_err,
    output logic                          busy,
    output logic                          timeout_evt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_cand;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_found;
    logic            w_wr;
    logic            w_rd;
    logic            w_legal;
    logic            w_timeout;
    logic [CW-1:0]   r_cnt;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_vld[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_wr      = req_wr_en[w_win];
    assign w_rd      = req_rd_en[w_win];
    assign w_legal   = w_wr | w_rd;
    assign w_ptr_nxt = (w_win == PTR_LAST) ? '0 : w_win + PW'(1);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = w_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                // An acknowledge on the last watchdog cycle still wins.
                if (if_ack_vld) begin
                    w_next = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_win       <= '0;
            r_cnt       <= '0;
            req_ack_vld <= '0;
            req_err     <= '0;
            req_rd_data <= '0;
            if_req_vld  <= 1'b0;
            if_wr_en    <= 1'b0;
            if_rd_en    <= 1'b0;
            if_addr     <= '0;
            if_wr_data  <= '0;
            if_soft_rst <= 1'b0;
            timeout_evt <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_ack_vld <= '0;
            req_err     <= '0;
            req_rd_data <= '0;
            if_req_vld  <= 1'b0;
            if_soft_rst <= 1'b0;
            timeout_evt <= 1'b0;
            busy        <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_win;
                        r_ptr <= w_ptr_nxt;
                        if (w_legal) begin
                            if_req_vld <= 1'b1;
                            if_wr_en   <= w_wr;
                            if_rd_en   <= w_rd & ~w_wr;
                            if_addr    <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                            if_wr_data <= req_wr_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            req_ack_vld[w_win] <= 1'b1;
                            req_err[w_win]     <= 1'b1;
                        end
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (w_next == S_RESP) begin
                        req_ack_vld[r_win] <= 1'b1;
                        req_err[r_win]     <= w_timeout | if_err;
                        if (!w_timeout && !if_wr_en) begin
                            req_rd_data[int'(r_win)*DATA_WIDTH +: DATA_WIDTH] <= if_rd_data;
                        end
                        if_soft_rst <= w_timeout;
                        timeout_evt <= w_timeout;
                        if_wr_en    <= 1'b0;
                        if_rd_en    <= 1'b0;
                        if_addr     <= '0;
                        if_wr_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
